uc_multiciclo: RTL

- Multi-cycle control unit for the 16-bit accumulator-less register CPU; successor to the single-cycle decoder.
- Sequences each instruction through FETCH/EXEC with an instruction-memory handshake.
- Adds CALL/RET via an internal parametrised return-address stack, plus a HALT state.
- Drives the PC muxes, register-file/flag write enables and ALU op of the datapath.

---
 rtl/uc_pkg.sv | 73 +++++++
 rtl/uc_multiciclo_if.sv | 51 +++++
 rtl/uc_ras.sv | 46 ++++
 rtl/uc_multiciclo.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/uc_pkg.sv
// Shared definitions for the multi-cycle control unit: FSM states, ALU
// operation codes, opcode patterns (value + care mask) and the classifier
// that maps a 6-bit opcode onto an instruction kind.
package uc_pkg;

    localparam int UC_OPC_W = 6;

    // Interrupt vector loaded into the PC by the datapath when s_vec=1.
    localparam logic [9:0] IRQ_VEC = 10'h3F0;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        HALT  = 2'd2,
        IRQ   = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        ALU_MOV  = 3'd0,
        ALU_NOT  = 3'd1,
        ALU_ADD  = 3'd2,
        ALU_SUB  = 3'd3,
        ALU_AND  = 3'd4,
        ALU_OR   = 3'd5,
        ALU_NEG1 = 3'd6,
        ALU_NEG2 = 3'd7
    } alu_op_e;

    typedef enum logic [3:0] {
        K_NOP, K_ALU, K_LI, K_HALT,
        K_JMP, K_JR, K_JZ, K_JNZ, K_JRZ, K_JRNZ,
        K_CALL, K_RET
    } instr_kind_e;

    // Opcode pattern: bits set in mask must equal the same bits of val.
    typedef struct packed {
        logic [UC_OPC_W-1:0] val;
        logic [UC_OPC_W-1:0] mask;
    } opc_pat_t;

    localparam opc_pat_t OPC_ALU  = '{val: 6'b000000, mask: 6'b100000};
    localparam opc_pat_t OPC_LI   = '{val: 6'b100000, mask: 6'b111100};
    localparam opc_pat_t OPC_HALT = '{val: 6'b100100, mask: 6'b111111};
    localparam opc_pat_t OPC_JMP  = '{val: 6'b111000, mask: 6'b111111};
    localparam opc_pat_t OPC_JR   = '{val: 6'b111001, mask: 6'b111111};
    localparam opc_pat_t OPC_JZ   = '{val: 6'b111010, mask: 6'b111111};
    localparam opc_pat_t OPC_JNZ  = '{val: 6'b111011, mask: 6'b111111};
    localparam opc_pat_t OPC_JRZ  = '{val: 6'b111100, mask: 6'b111111};
    localparam opc_pat_t OPC_JRNZ = '{val: 6'b111101, mask: 6'b111111};
    localparam opc_pat_t OPC_CALL = '{val: 6'b111110, mask: 6'b111111};
    localparam opc_pat_t OPC_RET  = '{val: 6'b111111, mask: 6'b111111};

    function automatic logic opc_is(logic [UC_OPC_W-1:0] opc, opc_pat_t p);
        return ((opc ^ p.val) & p.mask) == '0;
    endfunction

    // Anything not matching a pattern executes as a NOP.
    function automatic instr_kind_e classify(logic [UC_OPC_W-1:0] opc);
        if      (opc_is(opc, OPC_ALU))  return K_ALU;
        else if (opc_is(opc, OPC_LI))   return K_LI;
        else if (opc_is(opc, OPC_HALT)) return K_HALT;
        else if (opc_is(opc, OPC_JMP))  return K_JMP;
        else if (opc_is(opc, OPC_JR))   return K_JR;
        else if (opc_is(opc, OPC_JZ))   return K_JZ;
        else if (opc_is(opc, OPC_JNZ))  return K_JNZ;
        else if (opc_is(opc, OPC_JRZ))  return K_JRZ;
        else if (opc_is(opc, OPC_JRNZ)) return K_JRNZ;
        else if (opc_is(opc, OPC_CALL)) return K_CALL;
        else if (opc_is(opc, OPC_RET))  return K_RET;
        else                            return K_NOP;
    endfunction

endpackage

// File: rtl/uc_multiciclo_if.sv
// Bus between the control unit (master) and the datapath / instruction
// memory side (slave). The irq, irq_ack and s_vec signals exist only when
// UC_IRQ_EN is defined.
interface uc_multiciclo_if #(
    parameter int OP_W  = 6,
    parameter int ALU_W = 3,
    parameter int PC_W  = 10
);
    logic [OP_W-1:0]  opcode;
    logic             imem_ack;
    logic             z;
    logic [PC_W-1:0]  pc_plus1;
    logic             imem_req;
    logic             pc_en;
    logic             s_abs;
    logic             s_inc;
    logic             s_inm;
    logic             s_ret;
    logic             we3;
    logic             wez;
    logic [ALU_W-1:0] op_alu;
    logic [PC_W-1:0]  ret_addr;
    logic             halted;
    logic             stk_err;
`ifdef UC_IRQ_EN
    logic             irq;
    logic             irq_ack;
    logic             s_vec;
`endif

    modport master (
        input  opcode, imem_ack, z, pc_plus1,
`ifdef UC_IRQ_EN
        input  irq,
        output irq_ack, s_vec,
`endif
        output imem_req, pc_en, s_abs, s_inc, s_inm, s_ret,
               we3, wez, op_alu, ret_addr, halted, stk_err
    );

    modport slave (
        output opcode, imem_ack, z, pc_plus1,
`ifdef UC_IRQ_EN
        output irq,
        input  irq_ack, s_vec,
`endif
        input  imem_req, pc_en, s_abs, s_inc, s_inm, s_ret,
               we3, wez, op_alu, ret_addr, halted, stk_err
    );

endinterface

// File: rtl/uc_ras.sv
// Return-address stack: STK_DEPTH x PC_W LIFO. Only the stack pointer is
// reset; entries above the pointer are dead and need no clearing.
// top reads 0 when the stack is empty.
module uc_ras #(
    parameter int PC_W      = 10,
    parameter int STK_DEPTH = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [PC_W-1:0] din_i,
    output logic [PC_W-1:0] top_o,
    output logic            full_o,
    output logic            empty_o
);
    localparam int AW = $clog2(STK_DEPTH);

    logic [PC_W-1:0] mem_q [STK_DEPTH];
    logic [AW:0]     sp_q;
    logic [AW-1:0]   top_idx;

    assign full_o  = (sp_q == (AW+1)'(STK_DEPTH));
    assign empty_o = (sp_q == '0);
    assign top_idx = AW'(sp_q - 1'b1);
    assign top_o   = empty_o ? '0 : mem_q[top_idx];

    // Stack pointer: push grows, pop shrinks, guarded against over/underflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp_q <= '0;
        end else if (push_i && !full_o) begin
            sp_q <= sp_q + 1'b1;
        end else if (pop_i && !empty_o) begin
            sp_q <= sp_q - 1'b1;
        end
    end

    // Entry storage, written at the current pointer on a valid push.
    always_ff @(posedge clk) begin
        if (push_i && !full_o) begin
            mem_q[sp_q[AW-1:0]] <= din_i;
        end
    end

endmodule

// File: rtl/uc_multiciclo.sv
// Multi-cycle control unit: FETCH (instruction-memory handshake) then one
// EXEC cycle per instruction, CALL/RET through an internal return stack,
// and a HALT state left only by reset. All control outputs are registered:
// the EXEC-cycle controls are decoded from the opcode at the fetch edge.
// Optional interrupt entry is compiled in with the UC_IRQ_EN macro.
module uc_multiciclo
    import uc_pkg::*;
#(
    parameter int OP_W      = 6,
    parameter int ALU_W     = 3,
    parameter int PC_W      = 10,
    parameter int STK_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    uc_multiciclo_if.master   bus
);

    state_e           state_q;
    logic [OP_W-1:0]  ir_q;
    logic             imem_req_q;
    logic             pc_en_q;
    logic             s_abs_q;
    logic             s_inc_q;
    logic             s_inm_q;
    logic             s_ret_q;
    logic             we3_q;
    logic             wez_q;
    logic [ALU_W-1:0] op_alu_q;
    logic             halted_q;
    logic             stk_err_q;
`ifdef UC_IRQ_EN
    logic             irq_ack_q;
    logic             s_vec_q;
    logic             in_service_q;
`endif

    logic [UC_OPC_W-1:0] fetch_opc;
    instr_kind_e         fetch_kind;
    instr_kind_e         ir_kind;
    logic                fetch_fire;
    logic                ras_push;
    logic                ras_pop;
    logic [PC_W-1:0]     ras_din;
    logic [PC_W-1:0]     ras_top;
    logic                ras_full;
    logic                ras_empty;

    assign fetch_opc  = bus.opcode[OP_W-1 -: UC_OPC_W];
    assign fetch_kind = classify(fetch_opc);
    assign ir_kind    = classify(ir_q[OP_W-1 -: UC_OPC_W]);
    assign fetch_fire = (state_q == FETCH) && imem_req_q && bus.imem_ack;

    // pc_en_q is low in EXEC/IRQ exactly when the cycle was refused (stack
    // error or HALT), so it also gates the stack operations.
    assign ras_push = pc_en_q && ((state_q == EXEC && ir_kind == K_CALL) ||
                                  (state_q == IRQ));
    assign ras_pop  = pc_en_q && (state_q == EXEC) && (ir_kind == K_RET);
    // Interrupt entry saves the interrupted instruction's own address.
    assign ras_din  = (state_q == IRQ) ? bus.pc_plus1 - PC_W'(1) : bus.pc_plus1;

    uc_ras #(
        .PC_W      (PC_W),
        .STK_DEPTH (STK_DEPTH)
    ) u_ras (
        .clk     (clk),
        .reset   (reset),
        .push_i  (ras_push),
        .pop_i   (ras_pop),
        .din_i   (ras_din),
        .top_o   (ras_top),
        .full_o  (ras_full),
        .empty_o (ras_empty)
    );

    // Instruction register: captures the opcode on the accepted fetch.
    always_ff @(posedge clk) begin
        if (fetch_fire) begin
            ir_q <= bus.opcode;
        end
    end

    // Control FSM with registered outputs; every enable defaults to 0 so
    // they can only be high in the cycle following a fetch or IRQ decision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= FETCH;
            imem_req_q <= 1'b0;
            pc_en_q    <= 1'b0;
            s_abs_q    <= 1'b1;
            s_inc_q    <= 1'b1;
            s_inm_q    <= 1'b0;
            s_ret_q    <= 1'b0;
            we3_q      <= 1'b0;
            wez_q      <= 1'b0;
            op_alu_q   <= ALU_W'(ALU_MOV);
            halted_q   <= 1'b0;
            stk_err_q  <= 1'b0;
`ifdef UC_IRQ_EN
            irq_ack_q    <= 1'b0;
            s_vec_q      <= 1'b0;
            in_service_q <= 1'b0;
`endif
        end else begin
            imem_req_q <= 1'b0;
            pc_en_q    <= 1'b0;
            s_abs_q    <= 1'b1;
            s_inc_q    <= 1'b1;
            s_inm_q    <= 1'b0;
            s_ret_q    <= 1'b0;
            we3_q      <= 1'b0;
            wez_q      <= 1'b0;
            op_alu_q   <= ALU_W'(ALU_MOV);
`ifdef UC_IRQ_EN
            irq_ack_q  <= 1'b0;
            s_vec_q    <= 1'b0;
            if (ras_push && state_q == IRQ) begin
                in_service_q <= 1'b1;
            end else if (ras_pop) begin
                in_service_q <= 1'b0;
            end
`endif

            case (state_q)
                FETCH: begin
`ifdef UC_IRQ_EN
                    if (bus.irq && !in_service_q) begin
                        state_q <= IRQ;
                        if (ras_full) begin
                            stk_err_q <= 1'b1;
                        end else begin
                            pc_en_q   <= 1'b1;
                            s_vec_q   <= 1'b1;
                            irq_ack_q <= 1'b1;
                        end
                    end else
`endif
                    if (fetch_fire) begin
                        state_q <= EXEC;
                        pc_en_q <= 1'b1;
                        // z is a registered flag that only changes at the end
                        // of an EXEC with wez=1, so its value here is the value
                        // held throughout the coming EXEC cycle.
                        case (fetch_kind)
                            K_ALU: begin
                                we3_q    <= 1'b1;
                                wez_q    <= 1'b1;
                                op_alu_q <= ALU_W'(fetch_opc[4:2]);
                            end
                            K_LI: begin
                                we3_q   <= 1'b1;
                                s_inm_q <= 1'b1;
                            end
                            K_HALT: pc_en_q <= 1'b0;
                            K_JMP:  s_abs_q <= 1'b0;
                            K_JR:   s_inc_q <= 1'b0;
                            K_JZ:   s_abs_q <= !bus.z;
                            K_JNZ:  s_abs_q <= bus.z;
                            K_JRZ:  s_inc_q <= !bus.z;
                            K_JRNZ: s_inc_q <= bus.z;
                            K_CALL: begin
                                if (ras_full) begin
                                    pc_en_q   <= 1'b0;
                                    stk_err_q <= 1'b1;
                                end else begin
                                    s_abs_q <= 1'b0;
                                end
                            end
                            K_RET: begin
                                if (ras_empty) begin
                                    pc_en_q   <= 1'b0;
                                    stk_err_q <= 1'b1;
                                end else begin
                                    s_ret_q <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end else begin
                        imem_req_q <= 1'b1;
                    end
                end
                EXEC, IRQ: begin
                    // A refused cycle (pc_en low) is a HALT or a stack error.
                    if (pc_en_q) begin
                        state_q    <= FETCH;
                        imem_req_q <= 1'b1;
                    end else begin
                        state_q  <= HALT;
                        halted_q <= 1'b1;
                    end
                end
                HALT: ;
            endcase
        end
    end

    assign bus.imem_req = imem_req_q;
    assign bus.pc_en    = pc_en_q;
    assign bus.s_abs    = s_abs_q;
    assign bus.s_inc    = s_inc_q;
    assign bus.s_inm    = s_inm_q;
    assign bus.s_ret    = s_ret_q;
    assign bus.we3      = we3_q;
    assign bus.wez      = wez_q;
    assign bus.op_alu   = op_alu_q;
    assign bus.ret_addr = ras_top;
    assign bus.halted   = halted_q;
    assign bus.stk_err  = stk_err_q;
`ifdef UC_IRQ_EN
    assign bus.irq_ack  = irq_ack_q;
    assign bus.s_vec    = s_vec_q;
`endif

endmodule
